// File: rtl/rc_pulse_driver_pkg.sv
// Shared constants and FSM state type for the RC pulse driver and related
// actuator drivers.
package rc_pulse_driver_pkg;

  localparam int PERCENT_UPPER_BOUND = 100000;
  localparam int PERCENT_LOWER_BOUND = -100000;

  localparam int DEF_CYCLES_PER_US = 50;
  localparam int DEF_FRAME_US      = 20000;
  localparam int DEF_CENTER_US     = 1500;
  localparam int DEF_SPAN_US       = 500;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } state_t;

endpackage

// File: rtl/rc_pulse_driver_width_calc.sv
// Combinational command-to-pulse-width conversion: saturate the millipercent
// command, then scale it around the centre width.
module rc_width_calc
  import rc_pulse_driver_pkg::*;
#(
  parameter int CENTER_US = DEF_CENTER_US,
  parameter int SPAN_US   = DEF_SPAN_US
) (
  input  logic signed [31:0] control,
  output logic        [10:0] width_us
);

  localparam logic signed [47:0] UB       = 48'(PERCENT_UPPER_BOUND);
  localparam logic signed [47:0] LB       = 48'(PERCENT_LOWER_BOUND);
  localparam logic signed [47:0] SPAN48   = 48'(SPAN_US);
  localparam logic signed [47:0] CENTER48 = 48'(CENTER_US);

  logic signed [47:0] sat;
  logic signed [47:0] quot;

  always_comb begin
    sat = 48'(control);
    if (sat > UB) begin
      sat = UB;
    end else if (sat < LB) begin
      sat = LB;
    end
    // Signed division truncates toward zero, so -399 maps to -1 us.
    quot     = (sat * SPAN48) / UB;
    width_us = 11'(CENTER48 + quot);
  end

endmodule

// File: rtl/rc_pulse_driver.sv
// RC servo pulse generator: one pulse per fixed-length frame, width taken
// from the command sampled at the frame boundary.
module rc_pulse_driver
  import rc_pulse_driver_pkg::*;
#(
  parameter int CYCLES_PER_US = DEF_CYCLES_PER_US,
  parameter int FRAME_US      = DEF_FRAME_US,
  parameter int CENTER_US     = DEF_CENTER_US,
  parameter int SPAN_US       = DEF_SPAN_US
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic signed [31:0] control,
  output logic               pulse_out,
  output logic               frame_strobe,
  output logic        [10:0] pulse_us
);

  localparam int FRAME_CYCLES = FRAME_US * CYCLES_PER_US;
  localparam int CNT_W        = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             strobe_q, strobe_d;
  logic [10:0]      pulse_us_q, pulse_us_d;

  logic [10:0]      width_new;
  logic [31:0]      high_new;
  logic [31:0]      high_cur;
  logic [CNT_W-1:0] cnt_inc;
  logic             frame_end;

  rc_width_calc #(
    .CENTER_US (CENTER_US),
    .SPAN_US   (SPAN_US)
  ) u_width_calc (
    .control  (control),
    .width_us (width_new)
  );

  assign high_new  = 32'(width_new) * 32'(CYCLES_PER_US);
  assign high_cur  = 32'(pulse_us_q) * 32'(CYCLES_PER_US);
  assign cnt_inc   = cnt_q + 1'b1;
  assign frame_end = (state_q != ST_IDLE) && (cnt_q == LAST_CNT);

  // The latched command is held as its derived width; pulse_us_q doubles as
  // the frame's high-time reference so mid-frame control changes are ignored.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pulse_d    = pulse_q;
    strobe_d   = 1'b0;
    pulse_us_d = pulse_us_q;
    if ((state_q == ST_IDLE || frame_end) && enable) begin
      cnt_d      = '0;
      strobe_d   = 1'b1;
      pulse_us_d = width_new;
      pulse_d    = (high_new != '0);
      state_d    = pulse_d ? ST_HIGH : ST_LOW;
    end else if (frame_end) begin
      cnt_d   = '0;
      pulse_d = 1'b0;
      state_d = ST_IDLE;
    end else if (state_q != ST_IDLE) begin
      cnt_d   = cnt_inc;
      pulse_d = (32'(cnt_inc) < high_cur);
      state_d = pulse_d ? ST_HIGH : ST_LOW;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
      strobe_q   <= 1'b0;
      pulse_us_q <= 11'(CENTER_US);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
      strobe_q   <= strobe_d;
      pulse_us_q <= pulse_us_d;
    end
  end

  assign pulse_out    = pulse_q;
  assign frame_strobe = strobe_q;
  assign pulse_us     = pulse_us_q;

endmodule

// File: tb/tb_rc_pulse_driver.sv
// Self-checking bench for rc_pulse_driver at one clock cycle per microsecond,
// compared every cycle against a frame-level reference model.
module tb_rc_pulse_driver;

  localparam int FRAME = 20000;

  logic               clock = 1'b0;
  logic               reset;
  logic               enable;
  logic signed [31:0] control;
  logic               pulse_out;
  logic               frame_strobe;
  logic        [10:0] pulse_us;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  rc_pulse_driver #(
    .CYCLES_PER_US (1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .control      (control),
    .pulse_out    (pulse_out),
    .frame_strobe (frame_strobe),
    .pulse_us     (pulse_us)
  );

  function automatic int ref_width(input longint c);
    longint s;
    s = c;
    if (s > 100000) s = 100000;
    if (s < -100000) s = -100000;
    return int'(1500 + (s * 500) / 100000);
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Frame-level reference: active flag, position in frame, width of frame.
  logic m_act = 1'b0;
  int   m_cyc = 0;
  int   m_w   = 1500;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_act <= 1'b0;
      m_cyc <= 0;
      m_w   <= 1500;
    end else if ((!m_act || m_cyc == FRAME - 1) && enable) begin
      m_act <= 1'b1;
      m_cyc <= 0;
      m_w   <= ref_width(longint'(control));
    end else if (m_act && m_cyc == FRAME - 1) begin
      m_act <= 1'b0;
    end else if (m_act) begin
      m_cyc <= m_cyc + 1;
    end
  end

  always @(negedge clock) begin
    chk("cyc_pulse_out", longint'(pulse_out), longint'(m_act && (m_cyc < m_w)));
    chk("cyc_frame_strobe", longint'(frame_strobe), longint'(m_act && (m_cyc == 0)));
    chk("cyc_pulse_us", longint'(pulse_us), longint'(m_w));
  end

  // Samples n cycles; the first sampled negedge is expected to be frame cycle 0.
  task automatic run_frame(input int n, input int act_at, input int act_kind,
                           input logic signed [31:0] act_val,
                           output int hi, output int lo, output int s0,
                           output int extra, output int pu0);
    hi = 0; lo = 0; s0 = 0; extra = 0; pu0 = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (pulse_out) hi++; else lo++;
      if (i == 0) begin
        s0  = int'(frame_strobe);
        pu0 = int'(pulse_us);
      end else if (frame_strobe) begin
        extra++;
      end
      if (i == act_at) begin
        if (act_kind == 1) control = act_val;
        else if (act_kind == 2) enable = 1'b0;
      end
    end
  endtask

  task automatic restart(input logic signed [31:0] c);
    #1;
    reset   = 1'b1;
    control = c;
    enable  = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    logic signed [31:0] ctrl;
    int                 exp_w;
  } vec_t;

  vec_t vecs[6];
  int hi, lo, s0, extra, pu0;

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    control = '0;
    vecs[0] = '{32'sd250000, 2000};
    vecs[1] = '{-32'sd100000, 1000};
    vecs[2] = '{-32'sd399, 1499};
    vecs[3] = '{32'sd399, 1501};
    vecs[4] = '{32'h8000_0000, 1000};
    vecs[5] = '{32'sd0, 1500};

    repeat (3) @(negedge clock);
    chk("rst_pulse_out", longint'(pulse_out), 0);
    chk("rst_strobe", longint'(frame_strobe), 0);
    chk("rst_pulse_us", longint'(pulse_us), 1500);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("idle_pulse_out", longint'(pulse_out), 0);

    enable  = 1'b1;
    control = 32'sd0;
    run_frame(FRAME, -1, 0, 0, hi, lo, s0, extra, pu0);
    chk("f1_strobe0", s0, 1);
    chk("f1_high", hi, 1500);
    chk("f1_low", lo, 18500);
    chk("f1_extra_strobe", extra, 0);
    chk("f1_pulse_us", pu0, 1500);

    run_frame(FRAME, 700, 1, 32'sd100000, hi, lo, s0, extra, pu0);
    chk("f2_period_strobe", s0, 1);
    chk("f2_high_unchanged", hi, 1500);
    chk("f2_extra_strobe", extra, 0);
    chk("f2_pulse_us", pu0, 1500);

    run_frame(FRAME, 5000, 2, 0, hi, lo, s0, extra, pu0);
    chk("f3_strobe0", s0, 1);
    chk("f3_high_new_cmd", hi, 2000);
    chk("f3_pulse_us", pu0, 2000);
    chk("f3_extra_strobe", extra, 0);

    run_frame(10, -1, 0, 0, hi, lo, s0, extra, pu0);
    chk("idle_no_strobe", s0 + extra, 0);
    chk("idle_no_pulse", hi, 0);
    chk("idle_hold_us", longint'(pulse_us), 2000);

    enable = 1'b1;
    run_frame(2050, -1, 0, 0, hi, lo, s0, extra, pu0);
    chk("reen_strobe0", s0, 1);
    chk("reen_high", hi, 2000);

    foreach (vecs[k]) begin
      chk("model_width", ref_width(longint'(vecs[k].ctrl)), vecs[k].exp_w);
      restart(vecs[k].ctrl);
      run_frame(2050, -1, 0, 0, hi, lo, s0, extra, pu0);
      chk("vec_strobe0", s0, 1);
      chk("vec_high", hi, vecs[k].exp_w);
      chk("vec_pulse_us", pu0, vecs[k].exp_w);
    end

    restart(32'sd100000);
    run_frame(800, -1, 0, 0, hi, lo, s0, extra, pu0);
    chk("pre_rst_high", hi, 800);
    @(posedge clock);
    #2;
    chk("pre_rst_pulse", longint'(pulse_out), 1);
    reset = 1'b1;
    #1;
    chk("async_rst_pulse", longint'(pulse_out), 0);
    chk("async_rst_us", longint'(pulse_us), 1500);
    @(negedge clock);
    control = 32'sd0;
    reset   = 1'b0;
    run_frame(1600, -1, 0, 0, hi, lo, s0, extra, pu0);
    chk("post_rst_strobe0", s0, 1);
    chk("post_rst_high", hi, 1500);
    chk("post_rst_us", pu0, 1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rc_pulse_driver.md
RC_PULSE_DRIVER -- requirements
Module: rc_pulse_driver

Interface
REQ-001 Parameter CYCLES_PER_US, default 50, gives clock cycles per microsecond.
REQ-002 Parameter FRAME_US, default 20000, gives the servo frame period in microseconds.
REQ-003 Parameter CENTER_US, default 1500, gives the pulse width in microseconds for zero command.
REQ-004 Parameter SPAN_US, default 500, gives the pulse-width deviation in microseconds at ±100.000% command.
REQ-005 clock  input  1  single system clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  permits new frames; sampled only at frame boundaries.
REQ-008 control  input  32 signed  commanded actuator velocity in millipercent, from the PID block.
REQ-009 pulse_out  output  1  RC servo pulse line to the motor controller.
REQ-010 frame_strobe  output  1  high for exactly one cycle at the first cycle of each frame.
REQ-011 pulse_us  output  11 unsigned  pulse width in microseconds applied in the current frame.

Function
REQ-012 The block SHALL implement states IDLE, HIGH and LOW.
REQ-013 In IDLE, pulse_out=0 and frame_strobe=0, and pulse_us SHALL hold its last value.
REQ-014 At any rising edge where (state=IDLE or final LOW cycle reached) and enable=1, the block SHALL latch control and enter HIGH; the following cycle is frame cycle 0.
REQ-015 Latched control SHALL be saturated to [-100000, +100000] before scaling.
REQ-016 The width SHALL be computed as width_us = CENTER_US + (sat_control*SPAN_US)/100000, with signed division truncating toward zero; the defaults give 1000..2000.
REQ-017 Width arithmetic SHALL use at least 48-bit signed intermediates, with no overflow for any 32-bit control value.
REQ-018 The block SHALL compute high_cycles = width_us*CYCLES_PER_US and frame_cycles = FRAME_US*CYCLES_PER_US.
REQ-019 pulse_out SHALL be 1 for frame cycles 0..high_cycles-1 (HIGH) and 0 for cycles high_cycles..frame_cycles-1 (LOW).
REQ-020 frame_strobe SHALL be 1 in frame cycle 0 only.
REQ-021 pulse_us SHALL update in frame cycle 0 and hold for the frame.
REQ-022 Changes on control during a frame SHALL have no effect until the next frame boundary.
REQ-023 If enable=0 at the final LOW cycle, the block SHALL enter IDLE; deasserting enable mid-frame SHALL NOT truncate the current frame.
REQ-024 Consecutive enabled frames SHALL be back-to-back, with no gap cycle.
REQ-025 The frame counter SHALL be sized for frame_cycles-1 and SHALL NOT wrap within a frame.
REQ-026 pulse_out and frame_strobe SHALL be driven directly from flops, with no combinational path from any input.

Reset
REQ-027 While reset=1, the block SHALL hold: state IDLE, pulse_out=0, frame_strobe=0, pulse_us=CENTER_US, counter=0, latched control=0.
REQ-028 Reset asserted mid-frame SHALL force pulse_out low asynchronously, without waiting for a clock edge.
REQ-029 After reset deasserts, the first frame SHALL start at the first rising edge with enable=1.

Structure
REQ-030 The shared package SHALL hold: PERCENT_UPPER_BOUND=100000, PERCENT_LOWER_BOUND=-100000, the default timing constants, and the state enum.
REQ-031 Saturation and scaling SHALL be a combinational sub-module, rc_width_calc (control in, width_us out), reusable by other actuator drivers.

Verification (CYCLES_PER_US=1, defaults otherwise)
REQ-032 control=0, enable=1 -> pulse_out high for 1500 cycles and low for 18500 cycles, frame_strobe period 20000 cycles, pulse_us=1500.
REQ-033 control=100000 -> 2000 high cycles; control=250000 -> 2000; control=-100000 -> 1000; control=-399 -> 1499; control=399 -> 1501.
REQ-034 control changed from 0 to 100000 at frame cycle 700 -> current frame stays 1500 high, and the next frame is 2000 high.
REQ-035 enable dropped at frame cycle 5000 -> frame completes at 20000 cycles, then IDLE with pulse_out=0; re-enable -> frame_strobe on the next cycle after the edge.
REQ-036 reset pulsed at frame cycle 800 (pulse high) -> pulse_out=0 before the next clock edge, pulse_us=1500, and the first frame follows reset release.
REQ-037 control=0x80000000 (minimum int) -> pulse_us=1000 with no arithmetic wrap.
